synth_voice_bank: RTL

- Polyphonic successor to the single-voice oscillator: NUM_VOICES phase-accumulator voices share one waveform selector, one sine ROM and one mixer.
- Sits between the MIDI interpreter, which supplies note commands carrying a precomputed phase increment, and the audio DAC path.
- On each sample tick it walks all voices sequentially through a pipelined ROM/mixer and emits one averaged offset-binary sample.
- It also allocates voices to notes, retriggers repeated notes and, optionally, steals voices.

---
 rtl/synth_voice_bank_if.sv | 21 ++
 rtl/synth_voice_bank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/synth_voice_bank_if.sv
// Note-command channel from the MIDI interpreter into synth_voice_bank.
// The interpreter drives the command; the voice bank returns ready.
interface synth_voice_bank_if #(
    parameter int unsigned ACC_WIDTH = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_note_on;
    logic [6:0]           cmd_note;
    logic [ACC_WIDTH-1:0] cmd_phase_inc;

    modport master (
        output cmd_valid, cmd_note_on, cmd_note, cmd_phase_inc,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_note_on, cmd_note, cmd_phase_inc,
        output cmd_ready
    );
endinterface

// File: rtl/synth_voice_bank.sv
// Polyphonic phase-accumulator voice bank: allocates voices to notes and mixes all voices per sample tick.
// Optional voice stealing on a full bank is enabled by defining SYNTH_VOICE_STEAL_EN.
module synth_voice_bank #(
    parameter int unsigned NUM_VOICES    = 4,
    parameter int unsigned ACC_WIDTH     = 16,
    parameter int unsigned DAC_WIDTH     = 12,
    parameter int unsigned SIN_ADDR_BITS = 8
) (
    input  logic                  i_Clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic [1:0]            waveform_sel,
    synth_voice_bank_if.slave     cmd,
    output logic [DAC_WIDTH-1:0]  audio_out,
    output logic                  sample_valid,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  tick_dropped,
    output logic                  note_dropped
);
    localparam int unsigned VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned LOG2NV    = $clog2(NUM_VOICES);
    localparam int unsigned MW        = DAC_WIDTH + LOG2NV;
    localparam int unsigned ROM_DEPTH = 1 << SIN_ADDR_BITS;
    localparam int unsigned MID       = 1 << (DAC_WIDTH - 1);
    localparam int unsigned FRAC      = 28;
    localparam longint      TWO_PI_Q  = 64'sd1686629713;
    localparam longint      HALF_PI_Q = 64'sd421657428;
    localparam longint      ROUND_Q   = 64'sd134217728;
    localparam logic [VW-1:0] LAST    = VW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MIX, ST_DRAIN} state_t;

    // Elaboration-time sine entry in Q28 fixed point: quadrant fold plus Taylor series.
    function automatic int sine_entry(input int a);
        longint q, r, x, x2, term, sum, prod;
        int     quarter;
        quarter = int'(ROM_DEPTH / 4);
        q = longint'(a / quarter);
        r = longint'(a % quarter);
        x = (r * TWO_PI_Q) / longint'(ROM_DEPTH);
        if (q == 1 || q == 3) x = HALF_PI_Q - x;
        x2   = (x * x) >>> FRAC;
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> FRAC) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        if (q >= 2) sum = -sum;
        prod = longint'(MID - 1) * sum;
        if (prod >= 0) return int'(MID) + int'((prod + ROUND_Q) >>> FRAC);
        else           return int'(MID) - int'((-prod + ROUND_Q) >>> FRAC);
    endfunction

    logic [DAC_WIDTH-1:0] sine_rom [ROM_DEPTH];
    for (genvar a = 0; a < ROM_DEPTH; a++) begin : g_rom
        localparam logic [DAC_WIDTH-1:0] ENTRY = DAC_WIDTH'(sine_entry(a));
        assign sine_rom[a] = ENTRY;
    end

    state_t state_q, state_d;
    logic [VW-1:0] idx_q;
    logic cmd_ready_c, start_mix_c, issue_c, drain_c, tick_drop_c;

    logic [NUM_VOICES-1:0] active_q;
    logic [6:0]            note_q  [NUM_VOICES];
    logic [ACC_WIDTH-1:0]  inc_q   [NUM_VOICES];
    logic [ACC_WIDTH-1:0]  phase_q [NUM_VOICES];

    // State register
    always_ff @(posedge i_Clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sample_tick) state_d = ST_MIX;
            ST_MIX:   if (idx_q == LAST) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control decode; a tick outranks a command in IDLE
    always_comb begin
        cmd_ready_c = 1'b0;
        start_mix_c = 1'b0;
        issue_c     = 1'b0;
        drain_c     = 1'b0;
        tick_drop_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_c = !sample_tick;
                start_mix_c = sample_tick;
            end
            ST_MIX: begin
                issue_c     = 1'b1;
                tick_drop_c = sample_tick;
            end
            ST_DRAIN: begin
                drain_c     = 1'b1;
                tick_drop_c = sample_tick;
            end
            default: ;
        endcase
    end

    assign cmd.cmd_ready = cmd_ready_c;
    assign voice_active  = active_q;

    always_ff @(posedge i_Clk) begin
        if (reset)        idx_q <= '0;
        else if (issue_c) idx_q <= (idx_q == LAST) ? '0 : idx_q + VW'(1);
        else              idx_q <= '0;
    end

    // Lowest-index active voice holding the note, and lowest-index free voice
    logic          accept_c, any_hit_c, any_free_c;
    logic [VW-1:0] hit_idx_c, free_idx_c;
    always_comb begin
        accept_c   = cmd.cmd_valid && cmd_ready_c;
        any_hit_c  = 1'b0;
        any_free_c = 1'b0;
        hit_idx_c  = '0;
        free_idx_c = '0;
        for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
            if (active_q[v] && note_q[v] == cmd.cmd_note) begin
                any_hit_c = 1'b1;
                hit_idx_c = VW'(v);
            end
            if (!active_q[v]) begin
                any_free_c = 1'b1;
                free_idx_c = VW'(v);
            end
        end
    end

`ifdef SYNTH_VOICE_STEAL_EN
    logic [VW-1:0] steal_ptr_q;
`endif

    // Voice state: phase advance during MIX, note allocation while IDLE
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            active_q <= '0;
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                note_q[v]  <= '0;
                inc_q[v]   <= '0;
                phase_q[v] <= '0;
            end
`ifdef SYNTH_VOICE_STEAL_EN
            steal_ptr_q <= '0;
`endif
        end else begin
            if (issue_c && active_q[idx_q])
                phase_q[idx_q] <= phase_q[idx_q] + inc_q[idx_q];
            if (accept_c) begin
                if (cmd.cmd_note_on) begin
                    if (any_hit_c) begin
                        phase_q[hit_idx_c] <= '0;
                        inc_q[hit_idx_c]   <= cmd.cmd_phase_inc;
                    end else if (any_free_c) begin
                        active_q[free_idx_c] <= 1'b1;
                        note_q[free_idx_c]   <= cmd.cmd_note;
                        inc_q[free_idx_c]    <= cmd.cmd_phase_inc;
                        phase_q[free_idx_c]  <= '0;
                    end
`ifdef SYNTH_VOICE_STEAL_EN
                    else begin
                        note_q[steal_ptr_q]  <= cmd.cmd_note;
                        inc_q[steal_ptr_q]   <= cmd.cmd_phase_inc;
                        phase_q[steal_ptr_q] <= '0;
                        steal_ptr_q <= (steal_ptr_q == LAST) ? '0 : steal_ptr_q + VW'(1);
                    end
`endif
                end else if (any_hit_c) begin
                    active_q[hit_idx_c] <= 1'b0;
                end
            end
        end
    end

    // Waveform shaping from the pre-advance phase
    logic [ACC_WIDTH-1:0]     cur_phase_c;
    logic [SIN_ADDR_BITS-1:0] rom_addr_c;
    logic [DAC_WIDTH-1:0]     shape_c;
    assign cur_phase_c = phase_q[idx_q];
    assign rom_addr_c  = cur_phase_c[ACC_WIDTH-1 -: SIN_ADDR_BITS];
    always_comb begin
        shape_c = '0;
        case (waveform_sel)
            2'b00: shape_c = cur_phase_c[ACC_WIDTH-1 -: DAC_WIDTH];
            2'b01: shape_c = {DAC_WIDTH{cur_phase_c[ACC_WIDTH-1]}};
            2'b10: shape_c = cur_phase_c[ACC_WIDTH-1] ? ~cur_phase_c[ACC_WIDTH-2 -: DAC_WIDTH]
                                                      :  cur_phase_c[ACC_WIDTH-2 -: DAC_WIDTH];
            default: shape_c = '0;
        endcase
    end

    logic                 pipe_vld_q, pipe_act_q, pipe_sine_q;
    logic [DAC_WIDTH-1:0] shape_q, rom_q;
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            pipe_vld_q  <= 1'b0;
            pipe_act_q  <= 1'b0;
            pipe_sine_q <= 1'b0;
            shape_q     <= '0;
            rom_q       <= '0;
        end else begin
            pipe_vld_q  <= issue_c;
            pipe_act_q  <= active_q[idx_q];
            pipe_sine_q <= (waveform_sel == 2'b11);
            shape_q     <= shape_c;
            rom_q       <= sine_rom[rom_addr_c];
        end
    end

    // Signed mixer; the sum of NUM_VOICES offset-removed samples always fits MW bits
    logic [DAC_WIDTH-1:0] wave_c;
    logic signed [MW-1:0] contrib_c, acc_q, acc_next_c;
    assign wave_c     = pipe_sine_q ? rom_q : shape_q;
    assign contrib_c  = (pipe_vld_q && pipe_act_q) ? (MW'(wave_c) - MW'(MID)) : '0;
    assign acc_next_c = acc_q + contrib_c;

    always_ff @(posedge i_Clk) begin
        if (reset)            acc_q <= '0;
        else if (start_mix_c) acc_q <= '0;
        else if (pipe_vld_q)  acc_q <= acc_next_c;
    end

    always_ff @(posedge i_Clk) begin
        if (reset) begin
            audio_out    <= DAC_WIDTH'(MID);
            sample_valid <= 1'b0;
            tick_dropped <= 1'b0;
            note_dropped <= 1'b0;
        end else begin
            sample_valid <= drain_c;
            tick_dropped <= tick_drop_c;
            if (drain_c)
                audio_out <= DAC_WIDTH'(acc_next_c >>> LOG2NV) + DAC_WIDTH'(MID);
`ifdef SYNTH_VOICE_STEAL_EN
            note_dropped <= 1'b0;
`else
            note_dropped <= accept_c && cmd.cmd_note_on && !any_hit_c && !any_free_c;
`endif
        end
    end
endmodule
